// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: circular/linear coordinates, rotation/vectoring modes.
// One iteration per clock under an internal counter; the atan table sits outside
// the block and answers iter_idx combinationally on z_rom.
module cordic_engine #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 14,
    parameter int ITERS = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             in_ready,
    input  logic             mode_lin,
    input  logic             mode_vec,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic [CNT_W-1:0] iter_idx,
    input  logic [WIDTH-1:0] z_rom,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for start, in_ready high
    // RUN   | one CORDIC iteration per clock, k = counter
    // DONE  | results presented, waiting for out_ready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(ITERS - 1);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic                     lin_q, vec_q;
    logic signed [WIDTH-1:0]  x_q, y_q, z_q;
    logic signed [WIDTH-1:0]  x_d, y_d, z_d;
    logic [WIDTH-1:0]         xo_q, yo_q, zo_q;

    logic                     accept;
    logic                     last_iter;
    logic                     sigma_pos;
    logic signed [WIDTH-1:0]  x_sh, y_sh, e_k;
    logic [WIDTH-1:0]         e_lin;

    // Arithmetic right shift; shifting by WIDTH or more leaves only sign bits.
    function automatic logic signed [WIDTH-1:0] ash(input logic signed [WIDTH-1:0] v,
                                                    input logic [CNT_W-1:0] k);
        if (int'(k) >= WIDTH) begin
            return {WIDTH{v[WIDTH-1]}};
        end
        return v >>> k;
    endfunction

    assign accept    = in_ready && start;
    assign last_iter = (cnt_q == LAST_K);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)     state_d = S_RUN;
            S_RUN:   if (last_iter) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q == S_RUN) || (state_q == S_DONE);
        out_valid = (state_q == S_DONE);
        iter_idx  = (state_q == S_RUN) ? cnt_q : '0;
    end

    // One CORDIC micro-rotation; linear mode steps z by 2^(FRAC-k) and keeps x.
    always_comb begin
        e_lin = '0;
        if (int'(cnt_q) <= FRAC) begin
            e_lin = ONE << (FRAC - int'(cnt_q));
        end
        e_k       = lin_q ? e_lin : z_rom;
        sigma_pos = vec_q ? y_q[WIDTH-1] : ~z_q[WIDTH-1];
        x_sh      = ash(x_q, cnt_q);
        y_sh      = ash(y_q, cnt_q);
        if (sigma_pos) begin
            x_d = lin_q ? x_q : x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - e_k;
        end else begin
            x_d = lin_q ? x_q : x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + e_k;
        end
    end

    // Working registers, iteration counter and result registers.
    // The final iteration result goes straight to the outputs on the RUN->DONE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            lin_q <= 1'b0;
            vec_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            xo_q  <= '0;
            yo_q  <= '0;
            zo_q  <= '0;
        end else if (accept) begin
            cnt_q <= '0;
            lin_q <= mode_lin;
            vec_q <= mode_vec;
            x_q   <= x_in;
            y_q   <= y_in;
            z_q   <= z_in;
        end else if (state_q == S_RUN) begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
            if (last_iter) begin
                cnt_q <= '0;
                xo_q  <= x_d;
                yo_q  <= y_d;
                zo_q  <= z_d;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign x_out = xo_q;
    assign y_out = yo_q;
    assign z_out = zo_q;

endmodule

// File: tb/tb_cordic_engine.sv
// Scoreboard bench for cordic_engine: stimulus pushes expected results,
// a monitor pops and compares each time out_valid rises.
module tb_cordic_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_ready;
    logic        mode_lin = 1'b0;
    logic        mode_vec = 1'b0;
    logic [15:0] x_in = '0, y_in = '0, z_in = '0;
    logic [4:0]  iter_idx;
    logic [15:0] z_rom;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] x_out, y_out, z_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // round(atan(2^-k) * 2^14)
    int atan_tab [16] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128,
                          64, 32, 16, 8, 4, 2, 1, 0};

    typedef struct {
        string name;
        int    ex, ey, ez;
        int    tx, ty, tz;
    } exp_t;

    exp_t sb_q[$];

    cordic_engine #(.WIDTH(16), .FRAC(14), .ITERS(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_ready  (in_ready),
        .mode_lin  (mode_lin),
        .mode_vec  (mode_vec),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .iter_idx  (iter_idx),
        .z_rom     (z_rom),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_comb z_rom = 16'(atan_tab[iter_idx[3:0]]);

    function automatic int s16(input logic [15:0] v);
        logic signed [15:0] t;
        t = v;
        return int'(t);
    endfunction

    function automatic int wrap16(input int v);
        logic [15:0] b;
        b = v[15:0];
        return s16(b);
    endfunction

    // Reference CORDIC in plain integers, wrapped to 16 bits after every step.
    function automatic void model(input int x0, input int y0, input int z0,
                                  input bit lin, input bit vec,
                                  output int xr, output int yr, output int zr);
        int x, y, z, xs, ys, e, nx, ny, nz;
        bit up;
        x = x0; y = y0; z = z0;
        for (int k = 0; k < 16; k++) begin
            xs = x >>> k;
            ys = y >>> k;
            e  = lin ? ((k <= 14) ? (1 << (14 - k)) : 0) : atan_tab[k];
            up = vec ? (y < 0) : (z >= 0);
            nx = lin ? x : (up ? x - ys : x + ys);
            ny = up ? y + xs : y - xs;
            nz = up ? z - e : z + e;
            x  = wrap16(nx);
            y  = wrap16(ny);
            z  = wrap16(nz);
        end
        xr = x; yr = y; zr = z;
    endfunction

    task automatic check_eq(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_tol(input string nm, input logic [15:0] act, input int exp, input int tol);
        int d;
        if (tol < 0) return;
        checks++;
        d = s16(act) - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d +/- %0d", nm, s16(act), exp, tol);
        end
    endtask

    // Monitor: compare every new result against the oldest pending expectation.
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid && !prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got out_valid with empty queue, want none");
                end else begin
                    e = sb_q.pop_front();
                    check_tol({e.name, " x_out"}, x_out, e.ex, e.tx);
                    check_tol({e.name, " y_out"}, y_out, e.ey, e.ty);
                    check_tol({e.name, " z_out"}, z_out, e.ez, e.tz);
                end
            end
            prev = out_valid;
        end
    end

    // Issue one operation, optionally pulse start again at RUN cycle pulse_at,
    // and check latency. With keep=1 the result is left pending in DONE.
    task automatic run_op(input string nm, input int x, input int y, input int z,
                          input bit lin, input bit vec,
                          input int ex, input int ey, input int ez,
                          input int tx, input int ty, input int tz,
                          input int pulse_at, input bit keep);
        exp_t e;
        int   lat;
        bit   seen;
        out_ready = !keep;
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        check_eq({nm, " in_ready_before"}, int'(in_ready), 1);
        e.name = nm; e.ex = ex; e.ey = ey; e.ez = ez; e.tx = tx; e.ty = ty; e.tz = tz;
        sb_q.push_back(e);
        x_in = 16'(x); y_in = 16'(y); z_in = 16'(z);
        mode_lin = lin; mode_vec = vec;
        start = 1'b1;
        @(posedge clk);
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                x_in = 16'h5A5A; y_in = 16'hA5A5; z_in = 16'h1111;
                mode_lin = ~lin; mode_vec = ~vec;
            end
            if (i == pulse_at + 1) begin
                start = 1'b1;
                x_in = 16'h1000; y_in = 16'h0800; z_in = 16'hE000;
            end
            if (i == pulse_at + 2) start = 1'b0;
            @(posedge clk);
            #1;
            if (i == 5) begin
                check_eq({nm, " iter_idx"}, int'(iter_idx), 5);
                check_eq({nm, " run_flags"}, int'({busy, in_ready, out_valid}), 3'b100);
            end
            if (out_valid) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check_eq({nm, " latency"}, lat, 16);
        if (!keep) begin
            @(posedge clk);
            #1;
            check_eq({nm, " back_to_idle"}, int'({in_ready, out_valid, busy}), 3'b100);
        end
    endtask

    initial begin
        int wx, wy, wz;

        #2;
        check_eq("reset_flags", int'({in_ready, out_valid, busy}), 3'b100);
        check_eq("reset_outputs", int'(x_out | y_out | z_out), 0);
        check_eq("reset_iter_idx", int'(iter_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("circ_rot", 16'h26DD, 0, 16'h3244, 1'b0, 1'b0,
               11585, 11585, 0, 4, 4, 4, 5, 1'b0);

        // Abort an operation at iteration 7 with an asynchronous reset.
        @(negedge clk);
        x_in = 16'h2000; y_in = 16'h1000; z_in = 16'h1000;
        mode_lin = 1'b0; mode_vec = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check_eq("abort iter_idx", int'(iter_idx), 7);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort flags", int'({in_ready, out_valid, busy}), 3'b100);
        check_eq("abort x_out", int'(x_out), 0);
        check_eq("abort y_out", int'(y_out), 0);
        check_eq("abort z_out", int'(z_out), 0);
        check_eq("abort iter_idx0", int'(iter_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("circ_vec", 16'h2000, 16'h2000, 0, 1'b0, 1'b1,
               19078, 0, 12868, 4, 4, 4, -1, 1'b0);

        run_op("lin_rot", 16'h2000, 0, 16'h3000, 1'b1, 1'b0,
               8192, 6144, 0, 0, 2, -1, -1, 1'b0);

        run_op("lin_vec", 16'h4000, 16'h2000, 0, 1'b1, 1'b1,
               16384, 0, 8192, 0, 2, 2, -1, 1'b1);

        // Hold in DONE with start pulsing; results and flags must not move.
        for (int h = 0; h < 10; h++) begin
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            #1;
            check_eq("hold flags", int'({out_valid, in_ready, busy}), 3'b101);
            check_eq("hold x_out", int'(x_out), 16'h4000);
            check_eq("hold y_out", int'(y_out), 16'hFFFF);
            check_eq("hold z_out", int'(z_out), 16'h2001);
        end
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("release flags", int'({in_ready, out_valid, busy}), 3'b100);
        @(posedge clk);
        #1;
        check_eq("idle still", int'({in_ready, busy}), 2'b10);
        check_eq("idle x_out", int'(x_out), 16'h4000);
        check_eq("idle z_out", int'(z_out), 16'h2001);

        model(32767, 32767, 0, 1'b0, 1'b0, wx, wy, wz);
        run_op("wrap", 16'h7FFF, 16'h7FFF, 0, 1'b0, 1'b0,
               wx, wy, wz, 0, 0, 0, -1, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check_eq("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cordic_engine.md
Name: cordic_engine

Overview:
- Self-sequenced, parametrised iterative CORDIC engine.
- Supports circular and linear coordinate systems, each in rotation and vectoring mode.
- Uses a start/done handshake with an internal iteration counter, so no external sequencer drives the iteration index or mux selects.
- The atan table stays outside the block: the engine presents the iteration index and consumes the table value in the same cycle.

Parameters:
- WIDTH, 16: datapath width, two's-complement, for x, y and z.
- FRAC, 14: fractional bits of z and of the linear-mode step constant.
- ITERS, 16: iterations per operation; legal range 1..WIDTH.
- CNT_W, 5: iteration counter width; must satisfy 2^CNT_W > ITERS.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when in_ready=1.
- in_ready  out  1  high in IDLE.
- mode_lin  in  1  0=circular, 1=linear; sampled on accept.
- mode_vec  in  1  0=rotation, 1=vectoring; sampled on accept.
- x_in, y_in, z_in  in  WIDTH  operands; sampled on accept.
- iter_idx  out  CNT_W  current iteration k; 0 outside RUN.
- z_rom  in  WIDTH  atan(2^-k) in FRAC format; combinational response to iter_idx; used only in circular mode.
- out_valid  out  1  results valid (DONE state).
- out_ready  in  1  consumer accepts results.
- x_out, y_out, z_out  out  WIDTH  result registers.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, counter=0, x_out=y_out=z_out=0.
  - out_valid=0, busy=0, in_ready=1.
  - Reset mid-RUN or mid-DONE aborts immediately; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On the edge where start=1, latch x_in/y_in/z_in into the working registers.
  - Latch mode_lin/mode_vec, clear the counter, go to RUN.
- RUN:
  - One iteration per clock, k = counter = 0..ITERS-1.
  - On the edge with k=ITERS-1, go to DONE and copy the working registers to x_out/y_out/z_out.
- DONE:
  - out_valid=1 and outputs held stable.
  - On an edge with out_ready=1, go to IDLE.
  - start in the same cycle is not accepted, because in_ready is 0 in DONE.
- start while RUN/DONE is ignored, with no effect on the in-flight operation.
- Latency: acceptance edge E, out_valid rises after edge E+ITERS. With out_ready held high, in_ready returns after edge E+ITERS+1.
- Iteration arithmetic (sigma in {+1,-1}; >> is arithmetic right shift by k):
  - Rotation mode: sigma=+1 if z>=0 (sign bit 0), else -1.
  - Vectoring mode: sigma=+1 if y<0, else -1.
  - Circular: x' = x - sigma*(y>>k).
  - Linear: x' = x.
  - y' = y + sigma*(x>>k).
  - z' = z - sigma*e_k.
  - e_k = z_rom (circular), or 2^(FRAC-k) (linear; 0 when k>FRAC).
- Width rules:
  - All add/sub results are WIDTH bits, wrap modulo 2^WIDTH; no saturation, no overflow flag.
  - Shifts by k>=WIDTH yield all sign bits.
- No gain compensation: circular results carry gain ~1.6468; the caller pre-scales.
- Output registers change only on the RUN->DONE edge, and are otherwise stable, including through IDLE.

Test Plan:
Defaults apply; bench supplies an atan ROM as round(atan(2^-k)*2^14).
- Circular rotation: x=0x26DD, y=0, z=0x3244 (pi/4) -> x_out ~ y_out ~ 0x2D41 within +/-4 LSB, |z_out| <= 4 LSB; out_valid rises exactly 16 edges after accept.
- Circular vectoring: x=0x2000, y=0x2000, z=0 -> x_out ~ 0x4A86 (+/-4), y_out ~ 0 (+/-4), z_out ~ 0x3244 (+/-4).
- Linear rotation (multiply): x=0x2000, y=0, z=0x3000 -> x_out=0x2000 exactly, y_out ~ 0x1800 (+/-2); linear vectoring (divide): x=0x4000, y=0x2000, z=0 -> z_out ~ 0x2000 (+/-2), y_out ~ 0 (+/-2).
- Handshake:
  - Pulse start again at RUN cycle 5 with different operands -> ignored, first result unchanged.
  - Hold out_ready=0 for 10 cycles in DONE -> out_valid and outputs stable, in_ready=0.
  - out_ready=1 -> IDLE next edge.
- Reset mid-RUN: assert rst_n=0 asynchronously at iteration 7 -> all outputs 0 and in_ready=1 without a clock edge; a new start after release completes correctly with 16-cycle latency.
- Wrap boundary: circular rotation with x=0x7FFF, y=0x7FFF, z=0 -> outputs match a bit-accurate model that wraps mod 2^16, with no saturation.
